// File: rtl/disp_scan_arbiter.sv
// disp_scan_arbiter: two-client round-robin owner of a scanned 8-digit seven-segment display
module disp_scan_arbiter #(
    parameter int SCAN_DIV    = 16,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] seg_data0,
    input  logic [63:0] seg_data1,
    output logic [1:0]  gnt,
    output logic [7:0]  digit,
    output logic [7:0]  seg,
    output logic        frame_tick
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t        state_q, state_d, nxt_idle, nxt_own0, nxt_own1;
    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d, idx_n;
    logic [HW-1:0] hold_q, hold_d;
    logic          rr_q, rr_d, tick_q, tick_d, slot, boundary, expired;
    logic [7:0]    digit_q, digit_d, seg_q, seg_d;
    logic [63:0]   src;
    // next-state: scan position, ownership decided only at frame boundaries, registered display drive
    always_comb begin
        slot     = pre_q == PW'(SCAN_DIV - 1);
        boundary = slot && idx_q == 3'd7;
        idx_n    = idx_q + 3'd1;
        expired  = hold_q >= HW'(HOLD_FRAMES - 1);
        nxt_idle = (req0 && req1) ? (rr_q ? OWN1 : OWN0) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
        nxt_own0 = !req0 ? (req1 ? OWN1 : IDLE) : (expired && req1) ? OWN1 : OWN0;
        nxt_own1 = !req1 ? (req0 ? OWN0 : IDLE) : (expired && req0) ? OWN0 : OWN1;
        state_d  = !boundary ? state_q : state_q == OWN0 ? nxt_own0 : state_q == OWN1 ? nxt_own1 : nxt_idle;
        hold_d   = !boundary ? hold_q : (state_d != state_q || state_d == IDLE) ? '0 :
                   hold_q == HW'(HOLD_FRAMES) ? hold_q : hold_q + HW'(1);
        rr_d     = (boundary && state_d != state_q && state_d != IDLE) ? (state_d == OWN0) : rr_q;
        pre_d    = slot ? '0 : pre_q + PW'(1);
        idx_d    = slot ? idx_n : idx_q;
        src      = state_d == OWN1 ? seg_data1 : seg_data0;
        digit_d  = !slot ? digit_q : state_d == IDLE ? 8'hFF : ~(8'b1 << idx_n);
        seg_d    = !slot ? seg_q : state_d == IDLE ? 8'hFF : src[{idx_n, 3'b000} +: 8];
        tick_d   = boundary;
    end
    // state registers; reset aborts any scan in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            rr_q    <= 1'b0;
            digit_q <= 8'hFF;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end
    assign gnt        = {state_q == OWN1, state_q == OWN0};
    assign digit      = digit_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;
endmodule
